// File: rtl/mem_access_ctrl.sv
// Single-port memory initiator: arbitrates instruction fetch against load/store,
// checks alignment and func3 at accept, and runs one access per IDLE/ACCESS/RESP pass.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_valid,
  output logic              if_err,
  output logic [31:0]       if_inst,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_func3,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ready,
  output logic              dm_valid,
  output logic              dm_err,
  output logic [31:0]       dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_fetch,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_func3,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned      CNT_W      = $clog2(STARVE_MAX + 2);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  // Illegal func3 for the direction, or an address not aligned to the access size.
  function automatic logic access_bad(input logic fetch, input logic we,
                                      input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    if (fetch) begin
      bad = a[0];
    end else begin
      case (f3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = a[0];
        3'b010:  bad = |a;
        3'b100:  bad = we;
        3'b101:  bad = we | a[0];
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  state_e            state_q, state_d;
  logic              is_fetch_q, we_q, err_q;
  logic [2:0]        func3_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q, if_inst_q, dm_rdata_q;
  logic [CNT_W-1:0]  starve_q;

  logic              idle_s, fetch_win_s, acc_f_s, acc_d_s, acc_bad_s;
  logic [ADDR_W-1:0] acc_addr_s;

  // Readies are held low while reset is asserted so every output reads 0.
  assign idle_s      = (state_q == S_IDLE) && rst;
  assign fetch_win_s = if_req && (!dm_req || (starve_q == STARVE_LIM));
  assign if_ready    = idle_s && (fetch_win_s || (!if_req && !dm_req));
  assign dm_ready    = idle_s && !fetch_win_s && (dm_req || !if_req);
  assign acc_f_s     = if_req && if_ready;
  assign acc_d_s     = dm_req && dm_ready;
  assign acc_addr_s  = acc_f_s ? if_addr : dm_addr;
  assign acc_bad_s   = access_bad(acc_f_s, dm_we, dm_func3, acc_addr_s[1:0]);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a failed check skips the memory cycle entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (acc_f_s || acc_d_s) begin
          state_d = acc_bad_s ? S_RESP : S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes and response pulses decoded from the current state.
  always_comb begin
    mem_fetch = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_func3 = 3'b000;
    if_valid  = 1'b0;
    if_err    = 1'b0;
    dm_valid  = 1'b0;
    dm_err    = 1'b0;
    case (state_q)
      S_ACCESS: begin
        mem_fetch = is_fetch_q;
        mem_read  = !is_fetch_q && !we_q;
        mem_write = we_q;
        mem_func3 = func3_q;
      end
      S_RESP: begin
        if_valid = is_fetch_q;
        if_err   = is_fetch_q && err_q;
        dm_valid = !is_fetch_q;
        dm_err   = !is_fetch_q && err_q;
      end
      default: begin
        mem_fetch = 1'b0;
        if_valid  = 1'b0;
      end
    endcase
  end

  // Request latch, memory-side address/data hold, read capture and starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_fetch_q  <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      func3_q     <= 3'b000;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 32'h0000_0000;
      if_inst_q   <= 32'h0000_0000;
      dm_rdata_q  <= 32'h0000_0000;
      starve_q    <= {CNT_W{1'b0}};
    end else begin
      if (acc_f_s || acc_d_s) begin
        is_fetch_q <= acc_f_s;
        we_q       <= acc_d_s && dm_we;
        func3_q    <= acc_f_s ? 3'b010 : dm_func3;
        err_q      <= acc_bad_s;
        if (!acc_bad_s) begin
          mem_addr_q <= acc_addr_s;
          if (acc_d_s && dm_we) begin
            mem_wdata_q <= dm_wdata;
          end
        end
      end
      if (state_q == S_ACCESS) begin
        if (is_fetch_q) begin
          if_inst_q <= mem_rdata;
        end else if (!we_q) begin
          dm_rdata_q <= mem_rdata;
        end
      end
      if (acc_f_s) begin
        starve_q <= {CNT_W{1'b0}};
      end else if (acc_d_s && if_req && (starve_q != STARVE_LIM)) begin
        starve_q <= starve_q + CNT_W'(1);
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_inst   = if_inst_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: per-access vectors with hand-computed results,
// arbitration/starvation ordering, and reset abandoning an access mid-flight.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [8:0]  if_addr = 9'd0, dm_addr = 9'd0, mem_addr;
  logic [2:0]  dm_func3 = 3'd0, mem_func3;
  logic [31:0] dm_wdata = 32'd0, mem_rdata = 32'd0;
  logic        if_ready, if_valid, if_err, dm_ready, dm_valid, dm_err;
  logic        mem_fetch, mem_read, mem_write;
  logic [31:0] if_inst, dm_rdata, mem_wdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_if_inst = 32'd0;
  logic [31:0] exp_dm_rdata = 32'd0;

  typedef struct {
    logic        fetch;
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [13];

  mem_access_ctrl #(.ADDR_W(9), .STARVE_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid),
    .if_err(if_err), .if_inst(if_inst),
    .dm_req(dm_req), .dm_we(dm_we), .dm_func3(dm_func3), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_valid(dm_valid), .dm_err(dm_err),
    .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_fetch(mem_fetch), .mem_read(mem_read),
    .mem_write(mem_write), .mem_func3(mem_func3), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, 32'({if_ready, if_valid, if_err, dm_ready, dm_valid, dm_err,
                                 mem_fetch, mem_read, mem_write, mem_func3}), 32'd0);
    check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_inst"}, if_inst, 32'd0);
    check_eq({tag, "_rdata"}, dm_rdata, 32'd0);
  endtask

  // Called at a negedge with the controller idle; returns at the negedge 3 cycles after accept.
  task automatic run_vec(input int idx, input vec_t v);
    logic       ok;
    int         strobes, vcnt, vcyc;
    logic       got_err;
    logic [2:0] kind, exp_kind;
    string      t;
    t = $sformatf("v%0d", idx);
    if_req = v.fetch;  if_addr = v.addr;
    dm_req = !v.fetch; dm_addr = v.addr; dm_we = v.we; dm_func3 = v.f3; dm_wdata = v.wdata;
    mem_rdata = v.rdata;
    ok = 1'b0;
    for (int w = 0; w < 8 && !ok; w++) begin
      #1;
      ok = v.fetch ? if_ready : dm_ready;
      @(posedge clk);
    end
    check_eq({t, "_accept"}, 32'(ok), 32'd1);
    #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    strobes = 0; vcnt = 0; vcyc = 0; got_err = 1'b0;
    exp_kind = v.fetch ? 3'b100 : (v.we ? 3'b001 : 3'b010);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      kind = {mem_fetch, mem_read, mem_write};
      if (kind != 3'b000) begin
        strobes++;
        check_eq({t, "_kind"}, 32'(kind), 32'(exp_kind));
        check_eq({t, "_maddr"}, 32'(mem_addr), 32'(v.addr));
        check_eq({t, "_mf3"}, 32'(mem_func3), 32'(v.fetch ? 3'b010 : v.f3));
        if (v.we) check_eq({t, "_mwdata"}, mem_wdata, v.wdata);
      end
      if (if_valid || dm_valid) begin
        vcnt++;
        vcyc = c;
        got_err = v.fetch ? if_err : dm_err;
        check_eq({t, "_vside"}, 32'({if_valid, dm_valid}), 32'(v.fetch ? 2'b10 : 2'b01));
      end
    end
    check_eq({t, "_strobes"}, 32'(strobes), 32'(v.err ? 0 : 1));
    check_eq({t, "_vcnt"}, 32'(vcnt), 32'd1);
    check_eq({t, "_vlat"}, 32'(vcyc), 32'(v.err ? 1 : 2));
    check_eq({t, "_err"}, 32'(got_err), 32'(v.err));
    if (!v.err && v.fetch) exp_if_inst = v.rdata;
    if (!v.err && !v.fetch && !v.we) exp_dm_rdata = v.rdata;
    check_eq({t, "_inst"}, if_inst, exp_if_inst);
    check_eq({t, "_rdata"}, dm_rdata, exp_dm_rdata);
  endtask

  initial begin
    logic ok;
    int   n, g;
    logic [1:0] exp_grant [6];
    vec_t v;
    exp_grant = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    //          fetch  we    f3      addr     wdata          rdata          err
    vecs = '{
      '{1'b1, 1'b0, 3'b000, 9'd0,   32'd0,         32'h0000_0033, 1'b0},
      '{1'b0, 1'b0, 3'b010, 9'd4,   32'd0,         32'hDEAD_BEEF, 1'b0},
      '{1'b0, 1'b1, 3'b010, 9'd8,   32'd122,       32'h5555_5555, 1'b0},
      '{1'b0, 1'b0, 3'b001, 9'd2,   32'd0,         32'h0000_1234, 1'b0},
      '{1'b0, 1'b0, 3'b100, 9'd7,   32'd0,         32'h0000_00AB, 1'b0},
      '{1'b0, 1'b1, 3'b000, 9'd9,   32'h0000_00FF, 32'h6666_6666, 1'b0},
      '{1'b0, 1'b0, 3'b010, 9'd6,   32'd0,         32'h9999_9999, 1'b1},
      '{1'b0, 1'b0, 3'b001, 9'd3,   32'd0,         32'h9999_9999, 1'b1},
      '{1'b0, 1'b1, 3'b100, 9'd0,   32'h1111_1111, 32'h9999_9999, 1'b1},
      '{1'b1, 1'b0, 3'b000, 9'd5,   32'd0,         32'h9999_9999, 1'b1},
      '{1'b0, 1'b0, 3'b011, 9'd0,   32'd0,         32'h9999_9999, 1'b1},
      '{1'b0, 1'b1, 3'b101, 9'd0,   32'h2222_2222, 32'h9999_9999, 1'b1},
      '{1'b1, 1'b0, 3'b000, 9'h1FE, 32'd0,         32'hCAFE_F00D, 1'b0}
    };

    #1 rst = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Simultaneous requests: data first, fetch on the following IDLE.
    if_req = 1'b1; if_addr = 9'h010;
    dm_req = 1'b1; dm_we = 1'b0; dm_func3 = 3'b010; dm_addr = 9'd4;
    mem_rdata = 32'h1111_2222;
    #1;
    check_eq("both_ready", 32'({if_ready, dm_ready}), 32'(2'b01));
    @(posedge clk);
    #1 dm_req = 1'b0;
    ok = 1'b0; n = 0;
    for (int w = 0; w < 8 && !ok; w++) begin
      @(negedge clk);
      n++;
      ok = if_ready;
    end
    check_eq("fetch_next_idle", 32'(n), 32'd3);
    @(posedge clk);
    #1 if_req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("both_inst", if_inst, 32'h1111_2222);
    check_eq("both_rdata", dm_rdata, 32'h1111_2222);

    // Starvation limit of 2: D,D,F,D,D,F with both requests held.
    if_req = 1'b1; dm_req = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    g = 0;
    for (int cyc = 0; cyc < 40 && g < 6; cyc++) begin
      #1;
      if (if_ready || dm_ready) begin
        check_eq($sformatf("grant%0d", g), 32'({if_ready, dm_ready}), 32'(exp_grant[g]));
        g++;
      end
      @(posedge clk);
    end
    check_eq("grant_count", 32'(g), 32'd6);
    #1;
    if_req = 1'b0; dm_req = 1'b0;
    repeat (3) @(negedge clk);
    exp_if_inst = 32'h0BAD_F00D;
    exp_dm_rdata = 32'h0BAD_F00D;
    check_eq("starve_inst", if_inst, exp_if_inst);
    check_eq("starve_rdata", dm_rdata, exp_dm_rdata);

    // Reset during the ACCESS cycle of a store.
    dm_req = 1'b1; dm_we = 1'b1; dm_func3 = 3'b010; dm_addr = 9'd12; dm_wdata = 32'd55;
    #1;
    check_eq("rst_acc_ready", 32'(dm_ready), 32'd1);
    @(posedge clk);
    #1 dm_req = 1'b0;
    check_eq("rst_acc_write", 32'(mem_write), 32'd1);
    #1 rst = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (dm_valid) n++;
    end
    check_eq("rst_no_valid", 32'(n), 32'd0);
    exp_if_inst = 32'd0;
    exp_dm_rdata = 32'd0;
    v = '{1'b1, 1'b0, 3'b000, 9'd2, 32'd0, 32'h0000_0077, 1'b0};
    run_vec(20, v);
    v = '{1'b0, 1'b0, 3'b010, 9'd12, 32'd0, 32'h0000_0037, 1'b0};
    run_vec(21, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
